sa_fifo_ctrl_16x128: RTL
========================

// Module: sa_fifo_ctrl_16x128
// PURPOSE
//  Valid/ready FIFO controller that sequences one sa_ram_rws_16x128 instance (registered read address,
//  data on ram_dout the cycle after ram_re). Turns the bare 1R1W RAM into a 16-entry in-order FIFO.
//  The entry currently presented on the read side stays resident in the RAM. Used as the elastic
//  buffer between producer and consumer stages of the systolic-array datapath.
// PARAMETERS
//  DEPTH  16   number of entries; must equal the RAM depth and be a power of two
//  AW     4    address width = log2(DEPTH)
//  DW     128  payload width; must equal the RAM data width
// PORTS
//  nvdla_core_clk   in   1     single clock; all state on posedge
//  nvdla_core_rstn  in   1     asynchronous active-low reset
//  wr_pvld          in   1     producer data valid
//  wr_prdy          out  1     FIFO can accept (registered)
//  wr_pd            in   DW    producer payload
//  rd_pvld          out  1     head entry valid on rd_pd (registered)
//  rd_prdy          in   1     consumer accepts head
//  rd_pd            out  DW    head payload (= ram_dout)
//  ram_we           out  1     to RAM we
//  ram_wa           out  AW    to RAM wa
//  ram_di           out  DW    to RAM di (= wr_pd)
//  ram_re           out  1     to RAM re
//  ram_ra           out  AW    to RAM ra
//  ram_dout         in   DW    from RAM dout
//  fifo_count       out  AW+1  total occupancy 0..DEPTH, including the presented head
//  pwrbus_ram_pd    in   32    power-bus control, passed unchanged to ram_pwrbus_ram_pd
//  ram_pwrbus_ram_pd out 32    to RAM pwrbus_ram_pd
// BEHAVIOUR
//  State: wr_ptr[AW-1:0], rd_ptr[AW-1:0] (next RAM slot to fetch), count[AW:0], rd_pvld, wr_prdy.
//  Reset (async, rstn low): wr_ptr=0, rd_ptr=0, count=0, rd_pvld=0, wr_prdy=0.
//  - wr_prdy becomes 1 on the first clock edge after rstn deasserts. RAM contents are not cleared.
//  push = wr_pvld & wr_prdy.
//  - On push: ram_we=1, ram_wa=wr_ptr, ram_di=wr_pd in the same cycle; wr_ptr+1 (wraps DEPTH-1 -> 0).
//  pop = rd_pvld & rd_prdy.
//  unread = count - rd_pvld. This is the number of entries in the RAM that have not been fetched.
//  - It excludes any push in the current cycle; there is no same-cycle write->read bypass.
//  fetch = (unread != 0) & (~rd_pvld | pop).
//  - On fetch: ram_re=1, ram_ra=rd_ptr; rd_ptr+1 (wraps); rd_pvld<=1.
//  - Else if pop: rd_pvld<=0.
//  - Else rd_pvld holds.
//  When idle: ram_we=0 and ram_re=0; ram_wa tracks wr_ptr and ram_ra tracks rd_ptr.
//  rd_pd = ram_dout, combinational.
//  - No ram_re is issued while rd_pvld & ~rd_prdy, so rd_pd stays stable under backpressure.
//  count <= count + push - pop. fifo_count = count.
//  wr_prdy <= (count_next != DEPTH), registered.
//  - When the FIFO is full, a pop raises wr_prdy one cycle later.
//  - A push and a pop in the same cycle leave count unchanged.
//  Latency:
//  - Push in cycle N into an empty FIFO -> fetch in N+1 -> rd_pvld=1 with data in N+2.
//  - Steady state with rd_prdy=1 sustains 1 entry/cycle.
//  Write hazard: while count<DEPTH, wr_ptr never points at an occupied slot (including the held head).
//  - Simultaneous ram_we/ram_re always use different addresses.
//  Wrap-around: the pointers are plain AW-bit modulo counters; full and empty are decided by count only.
//  Reset mid-operation:
//  - All queued data is discarded.
//  - rd_pvld drops immediately (asynchronously); wr_prdy drops immediately.
//  Assertions (sim only):
//  - No push when count==DEPTH.
//  - No pop when count==0.
//  - rd_pd stable while rd_pvld & ~rd_prdy.
// TESTING
//  1 Reset, then push 0xA5..A5 at cycle 0 with rd_prdy=1.
//    -> ram_re in cycle 1; rd_pvld=1, rd_pd=0xA5..A5 in cycle 2; fifo_count 1 then 0.
//  2 rd_prdy=0; push 16 values 0..15.
//    -> wr_prdy=0 after the 16th push; fifo_count=16; rd_pd=0 held stable.
//  3 From full, pop one.
//    -> wr_prdy=1 on the next cycle; the next push writes wa=0 (wrap); the pop order continues 1,2,...
//  4 Continuous push and pop of 40 incrementing values with rd_prdy=1.
//    -> output is 0..39 in order, 1/cycle after 2-cycle fill; count stays <=2; pointers wrap twice.
//  5 Random wr_pvld/rd_prdy (50%) over 1000 values against a reference queue.
//    -> exact order match, no overflow or underflow, rd_pd stable whenever stalled.
//  6 Assert rstn low with count=7 mid-stream.
//    -> rd_pvld=0 and wr_prdy=0 immediately; after release, count=0; a new push reads back correctly.

Source files
------------

// File: rtl/sa_fifo_ctrl_16x128.sv
// sa_fifo_ctrl_16x128
//   In-order FIFO controller that sequences one external 1R1W RAM
//   (sa_ram_rws_16x128) as a 16-entry elastic buffer. The RAM has a
//   registered read, so data appears on ram_dout the cycle after ram_re.
//   The entry presented on the read side stays resident in the RAM and is
//   included in fifo_count.
//
// Ports
//   nvdla_core_clk     single clock; all state on posedge
//   nvdla_core_rstn    asynchronous active-low reset
//   wr_pvld/wr_prdy    producer handshake; wr_pd is the payload
//   rd_pvld/rd_prdy    consumer handshake; rd_pd is the head payload
//   ram_we/wa/di       RAM write port
//   ram_re/ra          RAM read request, ram_dout is the read data
//   fifo_count         occupancy 0..DEPTH, including the presented head
//   pwrbus_ram_pd      power-bus control, forwarded to ram_pwrbus_ram_pd
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds wr_pvld/wr_pd until accepted; this block holds
// rd_pvld/rd_pd until the consumer takes it. wr_prdy and rd_pvld are
// registered and never depend combinationally on the other side.
module sa_fifo_ctrl_16x128 #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 128
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   fifo_count,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   ram_pwrbus_ram_pd
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [AW:0]   unread;
  logic          push;
  logic          pop;
  logic          fetch;

  assign push = wr_pvld & wr_prdy;
  assign pop  = rd_pvld & rd_prdy;

  // Entries written but not yet fetched from the RAM. The held head has
  // already been fetched, so it is subtracted. A push in this same cycle is
  // not visible here: there is no write-to-read bypass through the RAM.
  assign unread = count - {{AW{1'b0}}, rd_pvld};

  // Fetch only when the output slot is empty or being vacated, which keeps
  // ram_dout (and therefore rd_pd) frozen under backpressure.
  assign fetch = (unread != '0) & (~rd_pvld | pop);

  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign ram_we            = push;
  assign ram_wa            = wr_ptr;
  assign ram_di            = wr_pd;
  assign ram_re            = fetch;
  assign ram_ra            = rd_ptr;
  assign rd_pd             = ram_dout;
  assign fifo_count        = count;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

  // Pointers are plain modulo counters; full/empty come from count alone.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_pvld <= 1'b0;
      wr_prdy <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (fetch) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_pvld <= 1'b1;
      end else if (pop) begin
        rd_pvld <= 1'b0;
      end
      count   <= count_next;
      // Registered: a pop from full re-opens the write side one cycle later.
      wr_prdy <= (count_next != FULL);
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (
    @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !(push && (count == FULL)));

  a_no_underflow: assert property (
    @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !(pop && (count == '0)));

  a_rd_pd_stable: assert property (
    @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    (rd_pvld && !rd_prdy) |=> $stable(rd_pd));
`endif

endmodule
